// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - parametrised VGA timing generator with key-selected test patterns
module vga_pattern_gen #(
  parameter int       H_ACTIVE = 640,
  parameter int       H_FP     = 16,
  parameter int       H_SYNC   = 96,
  parameter int       H_BP     = 48,
  parameter int       V_ACTIVE = 480,
  parameter int       V_FP     = 10,
  parameter int       V_SYNC   = 2,
  parameter int       V_BP     = 33,
  parameter int       CDEPTH   = 1,
  parameter int       NKEY     = 10,
  parameter bit       SYNC_POL = 1'b0,
  parameter int       CHK_LOG2 = 5
) (
  input  logic              ck_i,
  input  logic              rst_ni,
  input  logic [NKEY-1:0]   key_i,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              hvalid_o,
  output logic              vvalid_o,
  output logic [CDEPTH-1:0] r_o,
  output logic [CDEPTH-1:0] g_o,
  output logic [CDEPTH-1:0] b_o,
  output logic [9:0]        hcnt_o,
  output logic [9:0]        vcnt_o,
  output logic              frame_start_o
);

  localparam int HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int MW  = $clog2(NKEY);
  localparam int BW  = H_ACTIVE / 8;
  localparam int BPW = (BW > 1) ? $clog2(BW) : 1;

  localparam logic [9:0] H_LAST   = 10'(HT - 1);
  localparam logic [9:0] V_LAST   = 10'(VT - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]      hc_q, hc_d, vc_q, vc_d;
  logic [2:0]      bar_q, bar_d;
  logic [BPW-1:0]  bpos_q, bpos_d;
  logic [NKEY-1:0] ks1_q, ks2_q, kprev_q;
  logic [MW-1:0]   pend_q, pend_d, mode_q, mode_d;
  logic            pend_vld_q, pend_vld_d;

  logic              hsync_q, vsync_q, hvalid_q, vvalid_q, fs_q;
  logic              hsync_d, vsync_d, hvalid_d, vvalid_d, fs_d;
  logic [CDEPTH-1:0] r_q, g_q, b_q, r_d, g_d, b_d;
  logic [9:0]        hcnt_q, vcnt_q;

  logic            wrap_h, wrap_v, frame_wrap;
  logic [NKEY-1:0] rise;
  logic            rise_any;
  logic [MW-1:0]   rise_idx;
  logic [2:0]      colour;
  logic            vis;

  assign wrap_h     = (hc_q == H_LAST);
  assign wrap_v     = (vc_q == V_LAST);
  assign frame_wrap = wrap_h & wrap_v;

  always_comb begin
    hc_d   = wrap_h ? 10'd0 : hc_q + 10'd1;
    vc_d   = vc_q;
    bar_d  = bar_q;
    bpos_d = bpos_q;
    if (wrap_h) begin
      vc_d = wrap_v ? 10'd0 : vc_q + 10'd1;
    end
    // Bar index tracks hc/(H_ACTIVE/8) incrementally, avoiding a divider.
    if (wrap_h) begin
      bar_d  = 3'd0;
      bpos_d = '0;
    end else if (bpos_q == BPW'(BW - 1)) begin
      bar_d  = bar_q + 3'd1;
      bpos_d = '0;
    end else begin
      bpos_d = bpos_q + BPW'(1);
    end
  end

  assign rise     = ks2_q & ~kprev_q;
  assign rise_any = |rise;

  always_comb begin
    rise_idx = '0;
    for (int k = NKEY - 1; k >= 0; k--) begin
      if (rise[k]) rise_idx = MW'(k);
    end
  end

  // A new edge in the wrap cycle is kept for the following frame.
  always_comb begin
    mode_d     = mode_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (frame_wrap) begin
      if (pend_vld_q) mode_d = pend_q;
      pend_vld_d = rise_any;
      pend_d     = rise_any ? rise_idx : '0;
    end else if (rise_any) begin
      pend_vld_d = 1'b1;
      pend_d     = rise_idx;
    end
  end

  always_comb begin
    if (mode_q < MW'(8)) begin
      colour = mode_q[2:0];
    end else if (mode_q == MW'(8)) begin
      colour = bar_q;
    end else if (mode_q == MW'(9)) begin
      colour = (hc_q[CHK_LOG2] ^ vc_q[CHK_LOG2]) ? 3'b111 : 3'b000;
    end else begin
      colour = 3'b111;
    end
  end

  always_comb begin
    hvalid_d = (hc_q < H_VIS);
    vvalid_d = (vc_q < V_VIS);
    vis      = hvalid_d & vvalid_d;
    hsync_d  = ((hc_q >= HS_START) && (hc_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d  = ((vc_q >= VS_START) && (vc_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
    fs_d     = (hc_q == 10'd0) && (vc_q == 10'd0);
    r_d      = (vis && colour[0]) ? {CDEPTH{1'b1}} : '0;
    g_d      = (vis && colour[1]) ? {CDEPTH{1'b1}} : '0;
    b_d      = (vis && colour[2]) ? {CDEPTH{1'b1}} : '0;
  end

  always_ff @(posedge ck_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hc_q       <= '0;
      vc_q       <= '0;
      bar_q      <= '0;
      bpos_q     <= '0;
      ks1_q      <= '0;
      ks2_q      <= '0;
      kprev_q    <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      mode_q     <= '0;
    end else begin
      hc_q       <= hc_d;
      vc_q       <= vc_d;
      bar_q      <= bar_d;
      bpos_q     <= bpos_d;
      ks1_q      <= key_i;
      ks2_q      <= ks1_q;
      kprev_q    <= ks2_q;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      mode_q     <= mode_d;
    end
  end

  always_ff @(posedge ck_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      hvalid_q <= 1'b0;
      vvalid_q <= 1'b0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      fs_q     <= 1'b0;
    end else begin
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hvalid_q <= hvalid_d;
      vvalid_q <= vvalid_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
      hcnt_q   <= hc_q;
      vcnt_q   <= vc_q;
      fs_q     <= fs_d;
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign hvalid_o      = hvalid_q;
  assign vvalid_o      = vvalid_q;
  assign r_o           = r_q;
  assign g_o           = g_q;
  assign b_o           = b_q;
  assign hcnt_o        = hcnt_q;
  assign vcnt_o        = vcnt_q;
  assign frame_start_o = fs_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - scoreboard bench for vga_pattern_gen
module tb_vga_pattern_gen;

  logic       ck = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] key = '0;
  logic       hsync, vsync, hvalid, vvalid, fs;
  logic [1:0] r, g, b;
  logic [9:0] hcnt, vcnt;

  vga_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CDEPTH(2), .NKEY(10), .SYNC_POL(1'b0), .CHK_LOG2(1)
  ) dut (
    .ck_i(ck), .rst_ni(rst_n), .key_i(key),
    .hsync_o(hsync), .vsync_o(vsync), .hvalid_o(hvalid), .vvalid_o(vvalid),
    .r_o(r), .g_o(g), .b_o(b), .hcnt_o(hcnt), .vcnt_o(vcnt),
    .frame_start_o(fs)
  );

  always #5 ck = ~ck;

  typedef struct packed {
    logic       hs, vs, hv, vv;
    logic [1:0] r, g, b;
    logic [9:0] hc, vc;
    logic       fs;
  } pix_t;

  pix_t dut_pix, rst_pix;
  pix_t exp_q[$];
  int   checks = 0, errors = 0, nprint = 0;
  int   mh = 0, mv = 0, mmode = 0, mpend = 0;
  bit   mpend_v = 0;
  int   cyc = 0, last_fs = -1;

  assign dut_pix = {hsync, vsync, hvalid, vvalid, r, g, b, hcnt, vcnt, fs};

  // Frame is 24x12: visible 16x8, hsync low at h 18..21, vsync low at v 9..10.
  function automatic pix_t expect_pix(int h, int v, int md);
    pix_t p;
    logic [2:0] c;
    p.hs = !(h >= 18 && h <= 21);
    p.vs = !(v >= 9 && v <= 10);
    p.hv = (h < 16);
    p.vv = (v < 8);
    p.hc = 10'(h);
    p.vc = 10'(v);
    p.fs = (h == 0 && v == 0);
    if (md < 8)       c = 3'(md);
    else if (md == 8) c = 3'(h / 2);
    else if (md == 9) c = (((h / 2) % 2) != ((v / 2) % 2)) ? 3'b111 : 3'b000;
    else              c = 3'b111;
    p.r = (p.hv && p.vv && c[0]) ? 2'd3 : 2'd0;
    p.g = (p.hv && p.vv && c[1]) ? 2'd3 : 2'd0;
    p.b = (p.hv && p.vv && c[2]) ? 2'd3 : 2'd0;
    return p;
  endfunction

  task automatic step();
    exp_q.push_back(expect_pix(mh, mv, mmode));
    mh++;
    if (mh == 24) begin
      mh = 0;
      mv++;
      if (mv == 12) begin
        mv = 0;
        if (mpend_v) begin
          mmode   = mpend;
          mpend_v = 0;
        end
      end
    end
    @(posedge ck);
  endtask

  task automatic goto_line(int v);
    do step(); while (!(mv == v && mh == 5));
  endtask

  task automatic set_keys(logic [9:0] k);
    logic [9:0] rise;
    rise = k & ~key;
    if (rise != 0) begin
      for (int i = 9; i >= 0; i--) if (rise[i]) mpend = i;
      mpend_v = 1;
    end
    key = k;
  endtask

  task automatic model_reset();
    mh = 0; mv = 0; mmode = 0; mpend = 0; mpend_v = 0;
  endtask

  task automatic chk_direct(string name, pix_t act, pix_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  always @(negedge ck) begin : monitor
    pix_t e;
    cyc++;
    if (!rst_n) begin
      last_fs = -1;
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (dut_pix !== e) begin
          errors++;
          if (nprint < 30) begin
            nprint++;
            $display("FAIL pixel h=%0d v=%0d act=%h exp=%h", e.hc, e.vc, dut_pix, e);
          end
        end
      end
      if (fs) begin
        if (last_fs >= 0) begin
          checks++;
          if (cyc - last_fs != 288) begin
            errors++;
            $display("FAIL frame_period act=%0d exp=288", cyc - last_fs);
          end
        end
        last_fs = cyc;
      end
    end
  end

  initial begin
    rst_pix    = '0;
    rst_pix.hs = 1'b1;
    rst_pix.vs = 1'b1;

    repeat (3) @(negedge ck);
    #1 chk_direct("reset_init", dut_pix, rst_pix);
    rst_n = 1'b1;
    model_reset();

    // Asynchronous reset in the middle of a frame.
    goto_line(5);
    @(negedge ck);
    #1 rst_n = 1'b0;
    #1 chk_direct("reset_async", dut_pix, rst_pix);
    @(negedge ck);
    #1 chk_direct("reset_hold", dut_pix, rst_pix);
    rst_n = 1'b1;
    model_reset();

    // Mode 3 selected mid-frame, visible from next frame.
    goto_line(4); set_keys(10'h008);
    goto_line(6); set_keys(10'h000);
    // Bits 2 and 5 together: lowest wins.
    goto_line(4); set_keys(10'h024);
    goto_line(6); set_keys(10'h000);
    // Bits 2,5 then 9 before the wrap: last edge overwrites.
    goto_line(4); set_keys(10'h024);
    goto_line(6); set_keys(10'h224);
    goto_line(8); set_keys(10'h000);
    // Colour bars.
    goto_line(4); set_keys(10'h100);
    goto_line(6); set_keys(10'h000);
    // Held key 4 for three frames, then released.
    goto_line(4); set_keys(10'h010);
    goto_line(4);
    goto_line(4);
    goto_line(4); set_keys(10'h000);
    goto_line(4);
    goto_line(4);

    @(negedge ck);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain act=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
